mdu_iter: RTL and testbench

- Multi-cycle multiply/divide unit; the sequential counterpart to the single-cycle ALU.
- Sits in EX beside the ALU and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and MTHI/MTLO in a single cycle.
- The hazard unit stalls MFHI/MFLO and any new MD op while busy is high.

---
 rtl/mdu_iter.sv | 184 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply and
// restoring divide, one bit per cycle. Optional macro MDU_FAST_MUL_EN: single-pass multiply.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDOp,
    input  logic             start,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       dbg_state
);
    // Handshake: start is a one-cycle request sampled only in IDLE while flush is low;
    // it is accepted iff busy is low, and done pulses for exactly one cycle per result.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sgn_op;
    logic               div_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign sgn_op = (MDOp == OP_MULT) || (MDOp == OP_DIV);
    assign div_op = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
    assign mag_a  = (sgn_op && A[WIDTH-1]) ? -A : A;
    assign mag_b  = (sgn_op && B[WIDTH-1]) ? -B : B;

    // Multiply: upper half (with carry bit) accumulates, whole register shifts right.
    assign mul_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, opnd_q};

    assign prod_fix = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign quot_fix = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod_fast;
    assign prod_fast = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (MDOp)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = div_op;
                            neg_d     = sgn_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_rem_d = sgn_op && div_op && A[WIDTH-1];
                            dz_d      = div_op && (B == '0);
                            opnd_d    = div_op ? mag_b : mag_a;
                            acc_d     = {{(WIDTH+1){1'b0}}, (div_op ? mag_a : mag_b)};
                            cnt_d     = CW'(WIDTH);
                            state_d   = S_CALC;
`ifdef MDU_FAST_MUL_EN
                            if (!div_op) begin
                                acc_d   = {1'b0, prod_fast};
                                state_d = S_FIX;
                            end
`endif
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = trial[WIDTH] ? {rem_sh, acc_q[WIDTH-2:0], 1'b0}
                                             : {trial, acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table of mul/div results with latency checks,
// plus hand sequences for MTHI/MTLO, ignored starts, flush and mid-op reset.
module tb_mdu_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   md_op = 3'b000;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .MDOp(md_op),
        .start(start), .flush(flush), .busy(busy), .done(done),
        .HI(hi), .LO(lo), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock, then settle past the edge; all driving and sampling happens here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int busy_cnt, output int done_cnt);
        md_op = op; a = va; b = vb; start = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (!busy) break;
        end
        step();
        if (done) done_cnt++;
    endtask

    function automatic int exp_busy(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
        if (op == 3'b001 || op == 3'b010) return 1;
`endif
        return W + 1;
    endfunction

    initial begin : main
        int bc, dc;
        logic [2:0]   seq_op;
        logic [W-1:0] seq_a, seq_b, seq_hi, seq_lo;

        vecs[0]  = '{"mult_neg3x5",   3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{"multu_max_x2",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{"divu_100_7",    3'b100, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{"div_neg7_2",    3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{"div_by_zero",   3'b011, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{"div_overflow",  3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"mult_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{"div_7_neg2",    3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"divu_max_16",   3'b100, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[9]  = '{"divu_by_zero",  3'b100, 32'h80000001, 32'h00000000, 32'h80000001, 32'hFFFFFFFF};
        vecs[10] = '{"div0_neg_a",    3'b011, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};

        // Reset state
        #12;
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // MTHI / MTLO take effect next edge with no busy/done
        md_op = 3'b101; a = 32'hAAAA5555; start = 1'b1;
        step();
        start = 1'b0;
        check("mthi_hi", 64'(hi), 64'hAAAA5555);
        check("mthi_busy", 64'(busy), 64'h0);
        check("mthi_done", 64'(done), 64'h0);
        md_op = 3'b110; a = 32'h5555AAAA; start = 1'b1;
        step();
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h5555AAAA);
        check("mtlo_hi_kept", 64'(hi), 64'hAAAA5555);

        // NOP codes are ignored
        md_op = 3'b000; a = 32'h11111111; start = 1'b1;
        step();
        md_op = 3'b111;
        step();
        start = 1'b0;
        check("nop_busy", 64'(busy), 64'h0);
        check("nop_hilo", {hi, lo}, {32'hAAAA5555, 32'h5555AAAA});

        // flush beats start in IDLE
        md_op = 3'b101; a = 32'h22222222; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_start_hi", 64'(hi), 64'hAAAA5555);
        check("flush_start_busy", 64'(busy), 64'h0);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, dc);
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
            check({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'(exp_busy(vecs[i].op)));
            check({vecs[i].name, "_done_pulses"}, 64'(dc), 64'h1);
        end

        // MTLO while busy is ignored
`ifdef MDU_FAST_MUL_EN
        seq_op = 3'b100; seq_a = 32'd100; seq_b = 32'd7; seq_hi = 32'd2; seq_lo = 32'd14;
`else
        seq_op = 3'b001; seq_a = 32'd3; seq_b = 32'd4; seq_hi = 32'd0; seq_lo = 32'd12;
`endif
        md_op = seq_op; a = seq_a; b = seq_b; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        md_op = 3'b110; a = 32'hDEADBEEF; start = 1'b1;
        step();
        start = 1'b0;
        check("busy_mtlo_lo_kept", 64'(lo), 64'hFFFFFFFF);
        check("busy_mtlo_busy", 64'(busy), 64'h1);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            step();
        end
        check("busy_mtlo_hi", 64'(hi), 64'(seq_hi));
        check("busy_mtlo_lo", 64'(lo), 64'(seq_lo));

        // Flush mid-CALC: no write, no done
        step();
        md_op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("flush_pre_busy", 64'(busy), 64'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'h0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dc++;
        end
        check("flush_no_done", 64'(dc), 64'h0);
        check("flush_hilo", {hi, lo}, {seq_hi, seq_lo});

        // Asynchronous reset mid-CALC
        md_op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        check("rst_mid_busy", 64'(busy), 64'h0);
        check("rst_mid_done", 64'(done), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
